// File: rtl/pe_border_seq.sv
// pe_border_seq: edge sequencer that drives the strobes of the west/north border PE
module pe_border_seq #(
   parameter int IWIDTH = 8,
   parameter int CWIDTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CWIDTH-1:0] num_mac,
   input  logic              w_sign,
   input  logic [IWIDTH-2:0] w_abs,
   input  logic              ifm_valid,
   input  logic [IWIDTH-1:0] ifm_data,
   output logic              ifm_ready,
   output logic              en_i,
   output logic              clr_i,
   output logic              en_w,
   output logic              clr_w,
   output logic              en_o,
   output logic              clr_o,
   output logic              mac_done,
   output logic [IWIDTH-1:0] ifm,
   output logic              wght_sign,
   output logic [IWIDTH-2:0] wght_abs,
   output logic              busy,
   output logic              done
);
   typedef enum logic [2:0] {IDLE, LDW, WAIT_I, ISSUE, MUL, FIN} state_t;
   state_t            state, state_n;
   logic [IWIDTH-2:0] wcnt, wcnt_n;
   logic [CWIDTH-1:0] mcnt, mcnt_inc, num_q;
   logic              win_end;
   assign win_end   = &wcnt;
   assign mcnt_inc  = mcnt + CWIDTH'(1);
   assign wcnt_n    = (state == MUL) ? wcnt + (IWIDTH-1)'(1) : '0;
   assign ifm_ready = (state == WAIT_I);
   // next-state decode; the window end decides between another activation and job end
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = (num_mac == '0) ? FIN : LDW;
         LDW:     state_n = WAIT_I;
         WAIT_I:  if (ifm_valid) state_n = ISSUE;
         ISSUE:   state_n = MUL;
         MUL:     if (win_end) state_n = (mcnt_inc == num_q) ? FIN : WAIT_I;
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   // state and multiply-window counter; the window counter idles at zero outside MUL
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         wcnt  <= '0;
      end else begin
         state <= state_n;
         wcnt  <= wcnt_n;
      end
   end
   // job parameters latched on an accepted start, MAC count advanced at each window end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_q     <= '0;
         mcnt      <= '0;
         wght_sign <= 1'b0;
         wght_abs  <= '0;
      end else if (state == IDLE && start) begin
         num_q     <= num_mac;
         mcnt      <= '0;
         wght_sign <= w_sign;
         wght_abs  <= w_abs;
      end else if (state == MUL && win_end) begin
         mcnt <= mcnt_inc;
      end
   end
   // activation register, loaded on the stream handshake and held through the window
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ifm <= '0;
      else if (state == WAIT_I && ifm_valid) ifm <= ifm_data;
   end
   // strobes are registered from the next state so they line up with the state they belong to
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_i     <= 1'b0;
         clr_i    <= 1'b0;
         en_w     <= 1'b0;
         clr_w    <= 1'b0;
         en_o     <= 1'b0;
         clr_o    <= 1'b0;
         mac_done <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         en_i     <= (state_n == ISSUE);
         clr_i    <= (state_n == MUL) && (&wcnt_n);
         en_w     <= (state_n == LDW);
         clr_w    <= (state_n == FIN);
         en_o     <= (state_n == MUL);
         clr_o    <= (state_n == LDW);
         mac_done <= (state_n == MUL) && (&wcnt_n);
         busy     <= (state_n != IDLE);
         done     <= (state_n == FIN);
      end
   end
endmodule

// File: tb/tb_pe_border_seq.sv
// tb_pe_border_seq: scoreboard bench for the border PE sequencer (IWIDTH=4, CWIDTH=3)
module tb_pe_border_seq;
   localparam logic [7:0] EN_I = 8'h80, CLR_I = 8'h40, EN_W = 8'h20, CLR_W = 8'h10;
   localparam logic [7:0] EN_O = 8'h08, CLR_O = 8'h04, MDONE = 8'h02, DONE = 8'h01;
   typedef struct {
      int         cyc;
      logic [7:0] v;
      logic [3:0] f;
      logic       ci;
      logic       ws;
      logic [2:0] wa;
   } exp_t;
   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, w_sign = 1'b0, ifm_valid = 1'b0;
   logic [2:0] num_mac = '0, w_abs = '0, wght_abs;
   logic [3:0] ifm_data = '0, ifm;
   logic       ifm_ready, en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done, wght_sign, busy, done;
   int         cyc = 0, checks = 0, errors = 0, last_done = -1000;
   exp_t       q[$];
   logic [3:0] jd[8];
   int         js[8];
   pe_border_seq #(.IWIDTH(4), .CWIDTH(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_mac(num_mac), .w_sign(w_sign), .w_abs(w_abs),
      .ifm_valid(ifm_valid), .ifm_data(ifm_data), .ifm_ready(ifm_ready), .en_i(en_i), .clr_i(clr_i),
      .en_w(en_w), .clr_w(clr_w), .en_o(en_o), .clr_o(clr_o), .mac_done(mac_done), .ifm(ifm),
      .wght_sign(wght_sign), .wght_abs(wght_abs), .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   task automatic push(input int c, input logic [7:0] v, input logic [3:0] f, input logic ci,
                       input logic ws, input logic [2:0] wa);
      exp_t e;
      e.cyc = c; e.v = v; e.f = f; e.ci = ci; e.ws = ws; e.wa = wa;
      q.push_back(e);
   endtask
   // monitor: every cycle showing any strobe must match the next scoreboard entry
   always @(negedge clk) begin
      logic [7:0] v;
      exp_t       e;
      if (rst_n) begin
         v = {en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done, done};
         if (v != 8'h00) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_strobe: got %0h expected none (cycle %0d)", v, cyc);
            end else begin
               e = q.pop_front();
               chk("cycle", cyc, e.cyc);
               chk("strobes", v, e.v);
               chk("busy", busy, 1);
               chk("wght", {wght_sign, wght_abs}, {e.ws, e.wa});
               if (e.ci) chk("ifm", ifm, e.f);
            end
            if (done) last_done = cyc;
         end
      end
   end
   task automatic run_job(input int n, input logic ws, input logic [2:0] wa, input bit inj, input int len);
      int c0, t, b;
      @(negedge clk);
      c0 = cyc;
      start = 1'b1; num_mac = 3'(n); w_sign = ws; w_abs = wa;
      ifm_data = jd[0]; ifm_valid = (n > 0 && js[0] == 0);
      if (n == 0) push(c0 + 1, CLR_W | DONE, 4'h0, 1'b0, ws, wa);
      else begin
         push(c0 + 1, EN_W | CLR_O, 4'h0, 1'b0, ws, wa);
         t = c0 + 2;
         for (int k = 0; k < n; k++) begin
            t += js[k];
            push(t + 1, EN_I, jd[k], 1'b1, ws, wa);
            for (int j = 0; j < 8; j++) push(t + 2 + j, (j == 7) ? (EN_O | CLR_I | MDONE) : EN_O, jd[k], 1'b1, ws, wa);
            t += 10;
         end
         push(t, CLR_W | DONE, 4'h0, 1'b0, ws, wa);
      end
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < n; k++) begin
         b = 0;
         while (!ifm_ready && b < 100) begin
            @(negedge clk);
            b++;
         end
         if (!ifm_ready) begin
            chk("ready_timeout", ifm_ready, 1);
            break;
         end
         for (int i = 0; i < js[k]; i++) begin
            chk("stall_ready", ifm_ready, 1);
            @(negedge clk);
         end
         ifm_valid = 1'b1;
         ifm_data = jd[k];
         @(negedge clk);
         ifm_valid = (k + 1 < n) && (js[k+1] == 0);
         if (k + 1 < n) ifm_data = jd[k+1];
         if (inj && k == 0) begin
            repeat (2) @(negedge clk);
            start = 1'b1; num_mac = 3'd5; w_sign = ~ws; w_abs = ~wa;
            @(negedge clk);
            start = 1'b0;
         end
      end
      while (cyc < c0 + len + 2) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      chk("done_latency", last_done - c0, len);
      chk("idle_busy", busy, 0);
      chk("idle_ready", ifm_ready, 0);
   endtask
   initial begin
      int c0;
      start = 1'b1; ifm_valid = 1'b1; num_mac = 3'd2;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done, done, busy, ifm_ready,
                            ifm, wght_sign, wght_abs}, 0);
      start = 1'b0; ifm_valid = 1'b0;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_reset_idle", {busy, ifm_ready}, 0);
      jd[0] = 4'hD; jd[1] = 4'h7; js[0] = 0; js[1] = 0;
      run_job(2, 1'b1, 3'd5, 1'b0, 22);
      js[1] = 5;
      run_job(2, 1'b1, 3'd5, 1'b0, 27);
      js[1] = 0;
      run_job(0, 1'b0, 3'd3, 1'b0, 1);
      jd[0] = 4'h2; jd[1] = 4'h9;
      run_job(2, 1'b0, 3'd6, 1'b1, 22);
      jd = '{4'h1, 4'h8, 4'hF, 4'h4, 4'h0, 4'h6, 4'hB, 4'h0};
      js = '{0, 0, 0, 0, 0, 0, 0, 0};
      run_job(7, 1'b1, 3'd7, 1'b0, 72);
      // abort mid-window: reset lands while the window count is 3
      @(negedge clk);
      c0 = cyc;
      start = 1'b1; num_mac = 3'd2; w_sign = 1'b0; w_abs = 3'd3; ifm_data = 4'h6; ifm_valid = 1'b1;
      push(c0 + 1, EN_W | CLR_O, 4'h0, 1'b0, 1'b0, 3'd3);
      push(c0 + 3, EN_I, 4'h6, 1'b1, 1'b0, 3'd3);
      for (int j = 0; j < 4; j++) push(c0 + 4 + j, EN_O, 4'h6, 1'b1, 1'b0, 3'd3);
      @(negedge clk);
      start = 1'b0;
      while (cyc < c0 + 7) @(negedge clk);
      chk("pre_abort_en_o", en_o, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_en_o", en_o, 0);
      chk("abort_busy_done", {busy, done}, 0);
      chk("abort_queue", q.size(), 0);
      ifm_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("abort_idle", busy, 0);
      jd[0] = 4'hD; jd[1] = 4'h7;
      run_job(2, 1'b1, 3'd5, 1'b0, 22);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pe_border_seq.md
Name: pe_border_seq

Overview:
Edge sequencer that drives the west/north border PE of the unary-temporal systolic array. It accepts one weight per job and a valid/ready stream of signed input activations. For each activation it issues the register-enable, register-clear and mac_done strobes the border PE consumes, and it spaces the activations by one full temporal multiply window. The strobes then ripple through the array via each PE's one-cycle delayed copies.

Parameters:
IWIDTH, 8, activation/weight width including sign; the multiply window is 2^(IWIDTH-1) cycles.
CWIDTH, 16, width of the per-job MAC count.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  job start pulse; sampled only in IDLE
num_mac  input  CWIDTH  number of activations in the job; sampled with start
w_sign  input  1  weight sign; sampled with start
w_abs  input  IWIDTH-1  weight magnitude; sampled with start
ifm_valid  input  1  activation stream valid
ifm_data  input  IWIDTH  signed activation
ifm_ready  output  1  activation stream ready
en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done  output  1 each  PE control strobes
ifm  output  IWIDTH  activation presented to the PE
wght_sign  output  1  weight sign to the PE
wght_abs  output  IWIDTH-1  weight magnitude to the PE
busy  output  1  high in every state except IDLE
done  output  1  one-cycle job-complete pulse

Behaviour:
- All outputs are driven from flops, except ifm_ready, which is decoded from state. Reset value of every output is 0. Async reset asserted mid-job: immediate return to IDLE, all counters cleared, no done pulse.
- States: IDLE, LDW, WAIT_I, ISSUE, MUL, FIN.
- IDLE
  - start=1 latches num_mac, w_sign and w_abs.
  - num_mac=0: go to FIN.
  - Otherwise: go to LDW.
  - start in any other state is ignored.
- LDW (1 cycle)
  - en_w=1 and clr_o=1.
  - wght_sign/wght_abs show the latched weight from this cycle on and hold it until the next accepted start.
  - Next state: WAIT_I.
- WAIT_I
  - ifm_ready=1.
  - On ifm_valid&ifm_ready, ifm_data is captured into the ifm output register. Next state: ISSUE.
  - Otherwise the FSM stays in WAIT_I and all strobes are 0.
- ISSUE (1 cycle)
  - en_i=1; ifm holds the captured value.
  - Clears the window counter. Next state: MUL.
- MUL
  - en_o=1 for exactly 2^(IWIDTH-1) cycles, counted by an (IWIDTH-1)-bit window counter.
  - Final window cycle (counter all-ones): mac_done=1 and clr_i=1 in the same cycle; the MAC counter increments.
  - If the incremented count equals num_mac, go to FIN; otherwise go to WAIT_I.
  - ifm holds its value through MUL.
- FIN (1 cycle)
  - done=1 and clr_w=1. Next state: IDLE.
  - num_mac=0 path: FIN without any en_w, en_i, en_o or mac_done.
- Per-MAC latency with zero stream stall: ISSUE(1) + MUL(2^(IWIDTH-1)) + WAIT_I(1) = 2^(IWIDTH-1)+2 cycles.
- Job length: 1 (LDW) + num_mac*(2^(IWIDTH-1)+2) + 1 (FIN).
- Each strobe is a clean single-cycle pulse, except en_o, which is a contiguous level per window.
- Simultaneous start and reset deassertion in the same cycle: start is honoured only once rst_n is high at the sampling edge.
- MAC counter is CWIDTH bits. num_mac=2^CWIDTH-1 completes without wrap.
- ifm_valid dropping while in WAIT_I only extends WAIT_I; no strobe fires.
- No combinational path from ifm_valid to ifm_ready.

Test Plan:
- Reset: hold rst_n=0 with start=1 and ifm_valid=1 → all outputs 0, busy=0, ifm_ready=0; release rst_n → FSM stays in IDLE until start.
- IWIDTH=4, num_mac=2, w_sign=1, w_abs=5, ifm stream {-3, 7} always valid
  - LDW at cycle 1: en_w=1, clr_o=1, wght_abs=5.
  - en_i pulses 10 cycles apart; each followed by 8 cycles of en_o.
  - mac_done and clr_i coincide with the 8th en_o cycle.
  - done=1 exactly 22 cycles after start.
- Stalled stream: same job, ifm_valid low 5 cycles in WAIT_I → ifm_ready high throughout; no en_i/en_o during the stall; done delayed by exactly 5 cycles.
- num_mac=0 → FIN one cycle after start: done=1, clr_w=1; never en_w, en_i or en_o.
- start asserted during MUL → ignored; num_mac and weight outputs unchanged; job completes with original count.
- rst_n pulsed low mid-MUL (window count 3) → en_o drops asynchronously; no done pulse; a fresh start then runs a full job normally.
